// File: rtl/seq_detector_fsm_pkg.sv
// seq_det_pkg: shared state encoding and size constants for the sequence detector.
package seq_det_pkg;
   typedef enum logic {FILL, ARMED} state_t;
   localparam int PATTERN_W_MAX = 16;
   localparam logic [PATTERN_W_MAX-1:0] PAT_RST_DEF = 16'b1011;
endpackage

// File: rtl/seq_detector_fsm_if.sv
// seq_detector_fsm_if: serial stream, pattern programming and match status bundle.
interface seq_detector_fsm_if #(
   parameter int PATTERN_W = 4,
   parameter int CNT_W = 8
);
   logic                 x_in;
   logic                 x_valid;
   logic [PATTERN_W-1:0] pattern;
   logic                 load;
   logic                 overlap;
   logic                 y_out;
   logic                 match_q;
   logic [CNT_W-1:0]     match_cnt;
   logic                 cnt_sat;
   modport master (output x_in, x_valid, pattern, load, overlap,
                   input  y_out, match_q, match_cnt, cnt_sat);
   modport slave  (input  x_in, x_valid, pattern, load, overlap,
                   output y_out, match_q, match_cnt, cnt_sat);
endinterface

// File: rtl/seq_detector_fsm_sat_counter.sv
// sat_counter: up-counter that sticks at all ones, with synchronous clear.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         sat
);
   assign sat = &count;
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else if (clr) count <= '0;
      else if (inc && !sat) count <= count + 1'b1;
endmodule

// File: rtl/seq_detector_fsm.sv
// seq_detector_fsm: programmable serial pattern detector with Mealy match and overlap select.
// Saturating match counter is built only when SEQDET_MATCH_CNT_EN is defined.
module seq_detector_fsm
   import seq_det_pkg::*;
#(
   parameter int PATTERN_W = 4,
   parameter int CNT_W = 8,
   parameter logic [PATTERN_W-1:0] PAT_RST = PATTERN_W'(PAT_RST_DEF)
) (
   input logic clk,
   input logic reset,
   seq_detector_fsm_if.slave bus
);
   localparam int FW = $clog2(PATTERN_W);
   localparam logic [FW-1:0] LAST = FW'(PATTERN_W - 1);
   state_t               state_q, state_d;
   logic [FW-1:0]        fill_q, fill_d;
   logic [PATTERN_W-2:0] hist_q, hist_d;
   logic [PATTERN_W-1:0] pat_q, pat_d;
   logic [PATTERN_W-1:0] win;
   logic                 y;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q     <= FILL;
         fill_q      <= '0;
         hist_q      <= '0;
         pat_q       <= PAT_RST;
         bus.match_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         hist_q      <= hist_d;
         pat_q       <= pat_d;
         bus.match_q <= y;
      end
   always_comb begin
      pat_d  = pat_q;
      hist_d = hist_q;
      fill_d = fill_q;
      win    = {hist_q, bus.x_in};
      y      = bus.x_valid & ~bus.load & (state_q == ARMED) & (win == pat_q);
      if (bus.load) begin
         pat_d  = bus.pattern;
         hist_d = '0;
         fill_d = '0;
      end else if (bus.x_valid) begin
         // non-overlapping match discards the history so the next match needs a full pattern
         hist_d = (y && !bus.overlap) ? '0 : win[PATTERN_W-2:0];
         fill_d = (y && !bus.overlap) ? '0 : (state_q == FILL) ? fill_q + 1'b1 : fill_q;
      end
      state_d = (fill_d == LAST) ? ARMED : FILL;
   end
   assign bus.y_out = y;
`ifdef SEQDET_MATCH_CNT_EN
   sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (y),
      .clr   (bus.load),
      .count (bus.match_cnt),
      .sat   (bus.cnt_sat)
   );
`else
   assign bus.match_cnt = '0;
   assign bus.cnt_sat   = 1'b0;
`endif
endmodule

// File: tb/tb_seq_detector_fsm.sv
// tb_seq_detector_fsm: directed checks of match timing, overlap, gaps, load, saturation, async reset.
module tb_seq_detector_fsm;
`ifdef SEQDET_MATCH_CNT_EN
   localparam bit CE = 1'b1;
`else
   localparam bit CE = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset;
   int   n = 0;
   int   fails = 0;
   seq_detector_fsm_if #(.PATTERN_W(4), .CNT_W(2)) bus ();
   seq_detector_fsm #(.PATTERN_W(4), .CNT_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [15:0] ecnt(input int k);
      return CE ? 16'(k) : 16'd0;
   endfunction
   task automatic bit_in(input logic b, input logic exp_y, input string tag);
      bus.x_valid = 1'b1;
      bus.x_in = b;
      #1 chk({tag, " y_out"}, 16'(bus.y_out), 16'(exp_y));
      @(posedge clk);
      #1 chk({tag, " match_q"}, 16'(bus.match_q), 16'(exp_y));
   endtask
   task automatic idle(input string tag);
      bus.x_valid = 1'b0;
      bus.x_in = 1'b1;
      #1 chk({tag, " idle y_out"}, 16'(bus.y_out), 16'd0);
      @(posedge clk);
      #1 chk({tag, " idle match_q"}, 16'(bus.match_q), 16'd0);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
   endtask
   task automatic feed(input logic [7:0] bits, input logic [7:0] ys, input int len, input string tag);
      for (int i = len - 1; i >= 0; i--) bit_in(bits[i], ys[i], tag);
   endtask
   initial begin
      reset = 1'b1;
      bus.x_in = 1'b0;
      bus.x_valid = 1'b0;
      bus.pattern = 4'b0000;
      bus.load = 1'b0;
      bus.overlap = 1'b1;
      #1;
      chk("rst y_out", 16'(bus.y_out), 16'd0);
      chk("rst match_q", 16'(bus.match_q), 16'd0);
      chk("rst match_cnt", 16'(bus.match_cnt), 16'd0);
      chk("rst cnt_sat", 16'(bus.cnt_sat), 16'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      feed(8'b1011, 8'b0001, 4, "basic");
      chk("basic cnt", 16'(bus.match_cnt), ecnt(1));
      idle("basic");
      do_reset();
      feed(8'b1011011, 8'b0001001, 7, "ovl1");
      chk("ovl1 cnt", 16'(bus.match_cnt), ecnt(2));
      do_reset();
      bus.overlap = 1'b0;
      feed(8'b1011011, 8'b0001000, 7, "ovl0");
      chk("ovl0 cnt", 16'(bus.match_cnt), ecnt(1));
      do_reset();
      bus.overlap = 1'b1;
      bit_in(1'b1, 1'b0, "gap");
      idle("gap");
      bit_in(1'b0, 1'b0, "gap");
      idle("gap");
      bit_in(1'b1, 1'b0, "gap");
      idle("gap");
      bit_in(1'b1, 1'b1, "gap");
      chk("gap cnt", 16'(bus.match_cnt), ecnt(1));
      feed(8'b101, 8'b000, 3, "preload");
      bus.load = 1'b1;
      bus.pattern = 4'b0110;
      bus.x_valid = 1'b1;
      bus.x_in = 1'b1;
      #1 chk("load y_out", 16'(bus.y_out), 16'd0);
      @(posedge clk);
      #1 bus.load = 1'b0;
      chk("load cnt", 16'(bus.match_cnt), 16'd0);
      chk("load match_q", 16'(bus.match_q), 16'd0);
      feed(8'b0110, 8'b0001, 4, "newpat");
      chk("newpat cnt", 16'(bus.match_cnt), ecnt(1));
      do_reset();
      bus.load = 1'b1;
      bus.pattern = 4'b1111;
      bus.x_valid = 1'b0;
      @(posedge clk);
      #1 bus.load = 1'b0;
      feed(8'b111111, 8'b000111, 6, "sat");
      chk("sat cnt3", 16'(bus.match_cnt), ecnt(3));
      chk("sat flag", 16'(bus.cnt_sat), ecnt(1));
      feed(8'b11, 8'b11, 2, "sat5");
      chk("sat hold cnt", 16'(bus.match_cnt), ecnt(3));
      chk("sat hold flag", 16'(bus.cnt_sat), ecnt(1));
      bus.x_valid = 1'b1;
      bus.x_in = 1'b1;
      #1 chk("armed y_out", 16'(bus.y_out), 16'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst y_out", 16'(bus.y_out), 16'd0);
      chk("arst match_q", 16'(bus.match_q), 16'd0);
      chk("arst match_cnt", 16'(bus.match_cnt), 16'd0);
      chk("arst cnt_sat", 16'(bus.cnt_sat), 16'd0);
      bus.x_valid = 1'b0;
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      feed(8'b101, 8'b000, 3, "post");
      bit_in(1'b1, 1'b1, "postpat");
      bus.x_valid = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
      $finish;
   end
endmodule
